lcd_rgb565_dither: RTL

//  Output stage between the 480x272 LCD timing/pattern generator and the LCD pins.

---
 rtl/lcd_pkg.sv | 34 +++
 rtl/lcd_dither_chan.sv | 63 ++++++
 rtl/lcd_rgb565_dither.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared LCD output-stage definitions: panel geometry, pixel formats and the
// 4x4 ordered-dither threshold matrix.
package lcd_pkg;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_V_ACTIVE = 272;

    typedef logic [3:0] bayer_t;

    // Row-major, indexed [row][col]
    localparam bayer_t BAYER4 [0:3][0:3] = '{
        '{4'd0,  4'd8,  4'd2,  4'd10},
        '{4'd12, 4'd4,  4'd14, 4'd6 },
        '{4'd3,  4'd11, 4'd1,  4'd9 },
        '{4'd15, 4'd7,  4'd13, 4'd5 }
    };

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef struct packed {
        logic [3:0] r4;
        logic [3:0] g4;
        logic [3:0] b4;
    } rgb444_t;

    function automatic bayer_t bayer_lookup(input logic [1:0] row, input logic [1:0] col);
        return BAYER4[row][col];
    endfunction

endpackage

// File: rtl/lcd_dither_chan.sv
// One colour channel of the ordered dither: stage 1 registers base value and the
// residue-vs-threshold decision, stage 2 applies the saturating increment and blanking.
import lcd_pkg::*;

module lcd_dither_chan #(
    parameter int IN_W  = 5,
    parameter int OUT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [IN_W-1:0]  i_value,
    input  logic [3:0]       i_t,
    input  logic             i_enable,
    input  logic             i_valid,
    output logic [OUT_W-1:0] o_value
);

    localparam int D = IN_W - OUT_W;
    localparam logic [OUT_W-1:0] MAX_VAL = '1;

    logic [OUT_W-1:0] w_base;
    logic [3:0]       w_res;
    logic [3:0]       w_ts;
    logic             w_inc;

    logic [OUT_W-1:0] r_base;
    logic             r_inc;
    logic             r_vld;
    logic [OUT_W-1:0] r_out;

    // Only the top D threshold bits are compared against the D dropped bits
    assign w_base = i_value[IN_W-1:D];
    assign w_res  = 4'(i_value[D-1:0]);
    assign w_ts   = i_t >> (4 - D);
    assign w_inc  = i_enable && (w_res > w_ts);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_base <= '0;
            r_inc  <= 1'b0;
            r_vld  <= 1'b0;
        end else begin
            r_base <= w_base;
            r_inc  <= w_inc;
            r_vld  <= i_valid;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out <= '0;
        end else if (!r_vld) begin
            r_out <= '0;
        end else if (r_inc && (r_base != MAX_VAL)) begin
            r_out <= r_base + OUT_W'(1);
        end else begin
            r_out <= r_base;
        end
    end

    assign o_value = r_out;

endmodule

// File: rtl/lcd_rgb565_dither.sv
// LCD output stage: RGB565 to RGB444 with 4x4 ordered dither (optionally rotated per
// frame), two-cycle aligned data/DE/sync pipeline, dither enable switched only at VSYNC.
import lcd_pkg::*;

module lcd_rgb565_dither #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter bit TEMPORAL        = 1'b1
) (
    input  logic       PixelClk,
    input  logic       RST,
    input  logic       dither_en,
    input  logic       in_de,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic [4:0] in_r,
    input  logic [5:0] in_g,
    input  logic [4:0] in_b,
    output logic       LCD_DE,
    output logic       LCD_HSYNC,
    output logic       LCD_VSYNC,
    output logic [3:0] LCD_R,
    output logic [3:0] LCD_G,
    output logic [3:0] LCD_B
);

    localparam logic SYNC_ASSERT = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
    localparam logic SYNC_IDLE   = ~SYNC_ASSERT;

    rgb565_t    w_pix;
    rgb444_t    w_out;
    logic       w_vs_edge;
    logic       w_de_fall;
    logic [1:0] w_f;
    logic [1:0] w_row;
    logic [1:0] w_col;
    bayer_t     w_t;
    logic [3:0] w_r;
    logic [3:0] w_g;
    logic [3:0] w_b;

    logic [1:0] r_x;
    logic [1:0] r_y;
    logic [1:0] r_frame;
    logic       r_de_prev;
    logic       r_vs_prev;
    logic       r_dither_en;
    logic [1:0] r_de_d;
    logic [1:0] r_hs_d;
    logic [1:0] r_vs_d;

    assign w_pix     = {in_r, in_g, in_b};
    assign w_vs_edge = (in_vsync == SYNC_ASSERT) && (r_vs_prev != SYNC_ASSERT);
    assign w_de_fall = !in_de && r_de_prev;

    assign w_f   = TEMPORAL ? r_frame : 2'd0;
    assign w_row = r_y + w_f;
    assign w_col = r_x + w_f;
    assign w_t   = bayer_lookup(w_row, w_col);

    // Counters describe the pixel currently on the inputs, before the pipeline
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            r_x         <= 2'd0;
            r_y         <= 2'd0;
            r_frame     <= 2'd0;
            r_de_prev   <= 1'b0;
            r_vs_prev   <= SYNC_IDLE;
            r_dither_en <= 1'b0;
        end else begin
            r_de_prev <= in_de;
            r_vs_prev <= in_vsync;

            if (in_de) begin
                r_x <= r_x + 2'd1;
            end else begin
                r_x <= 2'd0;
            end

            // A frame start clears y even if a line ends in the same cycle
            if (w_vs_edge) begin
                r_y         <= 2'd0;
                r_frame     <= r_frame + 2'd1;
                r_dither_en <= dither_en;
            end else if (w_de_fall) begin
                r_y <= r_y + 2'd1;
            end
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            r_de_d <= 2'b00;
            r_hs_d <= {2{SYNC_IDLE}};
            r_vs_d <= {2{SYNC_IDLE}};
        end else begin
            r_de_d <= {r_de_d[0], in_de};
            r_hs_d <= {r_hs_d[0], in_hsync};
            r_vs_d <= {r_vs_d[0], in_vsync};
        end
    end

    lcd_dither_chan #(.IN_W(5), .OUT_W(4)) u_chan_r (
        .i_clk    (PixelClk),
        .i_rst    (RST),
        .i_value  (w_pix.r5),
        .i_t      (w_t),
        .i_enable (r_dither_en),
        .i_valid  (in_de),
        .o_value  (w_r)
    );

    lcd_dither_chan #(.IN_W(6), .OUT_W(4)) u_chan_g (
        .i_clk    (PixelClk),
        .i_rst    (RST),
        .i_value  (w_pix.g6),
        .i_t      (w_t),
        .i_enable (r_dither_en),
        .i_valid  (in_de),
        .o_value  (w_g)
    );

    lcd_dither_chan #(.IN_W(5), .OUT_W(4)) u_chan_b (
        .i_clk    (PixelClk),
        .i_rst    (RST),
        .i_value  (w_pix.b5),
        .i_t      (w_t),
        .i_enable (r_dither_en),
        .i_valid  (in_de),
        .o_value  (w_b)
    );

    assign w_out = {w_r, w_g, w_b};

    assign LCD_DE    = r_de_d[1];
    assign LCD_HSYNC = r_hs_d[1];
    assign LCD_VSYNC = r_vs_d[1];
    assign LCD_R     = w_out.r4;
    assign LCD_G     = w_out.g4;
    assign LCD_B     = w_out.b4;

endmodule
